// File: rtl/perf_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module      : perf_fifo_responder
// Description : Peripheral-bus responder with a 32-byte register window.
//               CPU writes to DATA are pushed into a TX FIFO that is drained
//               by a valid/ready stream. CPU reads of STATUS/DROP get a
//               registered response one cycle after the request.
//
//               Register window (offset = perf_addr[4:3]):
//                 0 DATA   W: push into FIFO     R: returns 0
//                 1 STATUS R: {count[31:16], full[1], empty[0]}
//                 2 CTRL   W: bit0 flush, bit1 clear drop counter; R: 0
//                 3 DROP   R: dropped-push counter (saturating)
//
// Ports       : clk, rst          clock, synchronous active-high reset
//               perf_en/wren/addr/data  CPU peripheral bus request
//               perf_rdata/rvalid       read response (1-cycle pulse)
//               out_data/valid/ready    FIFO head stream
// Revision    : 1.0  initial release
// ============================================================================
module perf_fifo_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0001_0000_0000,
    parameter int          DEPTH     = 16,
    parameter int          CNT_W     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        perf_en,
    input  logic        perf_wren,
    input  logic [63:0] perf_addr,
    input  logic [63:0] perf_data,
    output logic [63:0] perf_rdata,
    output logic        perf_rvalid,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int               PTR_W      = CNT_W - 1;
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
    localparam logic [31:0]      C_DROP_MAX = 32'hFFFF_FFFF;
    localparam logic [1:0]       C_OFF_DATA = 2'd0;
    localparam logic [1:0]       C_OFF_STAT = 2'd1;
    localparam logic [1:0]       C_OFF_CTRL = 2'd2;
    localparam logic [1:0]       C_OFF_DROP = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      drop_q, drop_d;
    logic             out_valid_q, out_valid_d;
    logic             rvalid_q, rvalid_d;
    logic [63:0]      rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       hit_w;
    logic [1:0] off_w;
    logic       rd_req_w;
    logic       push_req_w;
    logic       ctrl_wr_w;
    logic       flush_w;
    logic       drop_clr_w;
    logic       full_w;
    logic       empty_w;
    logic       pop_w;
    logic       push_ok_w;
    logic       push_drop_w;
    logic [63:0] status_w;

    assign hit_w      = perf_en && (perf_addr[63:5] == BASE_ADDR[63:5]);
    assign off_w      = perf_addr[4:3];
    assign rd_req_w   = hit_w && !perf_wren;
    assign push_req_w = hit_w && perf_wren && (off_w == C_OFF_DATA);
    assign ctrl_wr_w  = hit_w && perf_wren && (off_w == C_OFF_CTRL);
    assign flush_w    = ctrl_wr_w && perf_data[0];
    assign drop_clr_w = ctrl_wr_w && perf_data[1];

    assign full_w  = (count_q == C_DEPTH);
    assign empty_w = (count_q == '0);

    // Pop is qualified by the registered out_valid, so a push into an empty
    // FIFO can never be popped in the same cycle.
    assign pop_w = out_valid_q && out_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_w   = push_req_w && (!full_w || pop_w);
    assign push_drop_w = push_req_w && !push_ok_w;

    assign status_w = {32'b0, {(16-CNT_W){1'b0}}, count_q, 14'b0, full_w, empty_w};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        drop_d      = drop_q;
        rvalid_d    = rd_req_w;
        rdata_d     = '0;

        if (flush_w) begin
            // Flush wins over a simultaneous pop; a push cannot coincide
            // because the bus carries a single access per cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_w) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok_w) - CNT_W'(pop_w);
        end

        if (drop_clr_w) begin
            drop_d = '0;
        end else if (push_drop_w && (drop_q != C_DROP_MAX)) begin
            drop_d = drop_q + 32'd1;
        end

        // Response reflects state sampled before this cycle's push/pop.
        if (rd_req_w) begin
            case (off_w)
                C_OFF_STAT: rdata_d = status_w;
                C_OFF_DROP: rdata_d = {32'b0, drop_q};
                default:    rdata_d = '0;
            endcase
        end

        out_valid_d = (count_d != '0);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            out_valid_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage needs no reset: stale entries are never visible because
    // out_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_w) begin
            mem_q[wr_ptr_q] <= perf_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign perf_rvalid = rvalid_q;
    assign perf_rdata  = rdata_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_valid_q ? mem_q[rd_ptr_q] : 64'b0;

endmodule
`default_nettype wire

// File: tb/tb_perf_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_fifo_responder
// Description : Self-checking bench for perf_fifo_responder. A queue-based
//               reference model tracks FIFO contents, drop counter and the
//               pending read response; directed steps are followed by a
//               randomized bus/consumer sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_perf_fifo_responder;

    localparam logic [63:0] C_BASE  = 64'h0000_0001_0000_0000;
    localparam int          C_DEPTH = 16;
    localparam int          C_CNT_W = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        perf_en;
    logic        perf_wren;
    logic [63:0] perf_addr;
    logic [63:0] perf_data;
    logic [63:0] perf_rdata;
    logic        perf_rvalid;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_q[$];
    logic [31:0] m_drop;

    always #5 clk = ~clk;

    perf_fifo_responder #(
        .BASE_ADDR (C_BASE),
        .DEPTH     (C_DEPTH),
        .CNT_W     (C_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .perf_en     (perf_en),
        .perf_wren   (perf_wren),
        .perf_addr   (perf_addr),
        .perf_data   (perf_data),
        .perf_rdata  (perf_rdata),
        .perf_rvalid (perf_rvalid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] status_of(input int n);
        logic [63:0] s;
        s        = 64'b0;
        s[31:16] = 16'(n);
        s[1]     = (n == C_DEPTH);
        s[0]     = (n == 0);
        return s;
    endfunction

    // One bus cycle: drive request, predict, clock, then compare.
    task automatic cycle(input logic en, input logic wren, input logic [63:0] addr,
                         input logic [63:0] data, input logic rdy, input string tag);
        logic        hit;
        logic [1:0]  off;
        logic        pop;
        logic        exp_rv;
        logic [63:0] exp_rd;
        perf_en   = en;
        perf_wren = wren;
        perf_addr = addr;
        perf_data = data;
        out_ready = rdy;

        hit    = en && (addr[63:5] == C_BASE[63:5]);
        off    = addr[4:3];
        pop    = (m_q.size() != 0) && rdy;
        exp_rv = hit && !wren;
        exp_rd = 64'b0;
        if (exp_rv) begin
            if (off == 2'd1)      exp_rd = status_of(m_q.size());
            else if (off == 2'd3) exp_rd = {32'b0, m_drop};
        end

        if (hit && wren && off == 2'd2 && data[0]) m_q.delete();
        else if (pop) void'(m_q.pop_front());
        if (hit && wren && off == 2'd0) begin
            if (m_q.size() < C_DEPTH) m_q.push_back(data);
            else if (m_drop != 32'hFFFF_FFFF) m_drop++;
        end
        if (hit && wren && off == 2'd2 && data[1]) m_drop = 32'b0;

        @(posedge clk);
        #1;
        chk({tag, ":rvalid"},    64'(perf_rvalid), 64'(exp_rv));
        chk({tag, ":rdata"},     perf_rdata, exp_rd);
        chk({tag, ":out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk({tag, ":out_data"}, out_data, m_q[0]);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 64'b0, 64'b0, rdy, "idle");
    endtask

    task automatic do_reset(input logic rd_during);
        rst       = 1'b1;
        perf_en   = rd_during;
        perf_wren = 1'b0;
        perf_addr = C_BASE + 64'h08;
        perf_data = 64'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        perf_en = 1'b0;
        m_q.delete();
        m_drop = 32'b0;
        chk("reset:rvalid",    64'(perf_rvalid), 64'b0);
        chk("reset:rdata",     perf_rdata, 64'b0);
        chk("reset:out_valid", 64'(out_valid), 64'b0);
        chk("reset:out_data",  out_data, 64'b0);
    endtask

    initial begin
        rst = 1'b1; perf_en = 1'b0; perf_wren = 1'b0;
        perf_addr = 64'b0; perf_data = 64'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // 1: STATUS after reset reads empty
        cycle(1'b1, 1'b0, C_BASE + 64'h08, 64'b0, 1'b0, "t1_rd_status");
        chk("t1_status_const", perf_rdata, 64'h1);
        idle(1'b0);

        // 2: three pushes held at the head
        cycle(1'b1, 1'b1, C_BASE, 64'hA1, 1'b0, "t2_push");
        chk("t2_first_valid", 64'(out_valid), 64'h1);
        cycle(1'b1, 1'b1, C_BASE + 64'h3, 64'hA2, 1'b0, "t2_push");
        cycle(1'b1, 1'b1, C_BASE, 64'hA3, 1'b0, "t2_push");
        cycle(1'b1, 1'b0, C_BASE + 64'h08, 64'b0, 1'b0, "t2_rd_status");
        chk("t2_status_const", perf_rdata, 64'h0003_0000);
        chk("t2_head_const", out_data, 64'hA1);

        // 3: drain
        for (int i = 0; i < 4; i++) idle(1'b1);

        // 4: overfill, then clear drop counter
        for (int i = 0; i < 17; i++)
            cycle(1'b1, 1'b1, C_BASE, 64'h100 + 64'(i), 1'b0, "t4_push");
        cycle(1'b1, 1'b0, C_BASE + 64'h08, 64'b0, 1'b0, "t4_rd_status");
        chk("t4_status_const", perf_rdata, 64'h0010_0002);
        cycle(1'b1, 1'b0, C_BASE + 64'h18, 64'b0, 1'b0, "t4_rd_drop");
        chk("t4_drop_const", perf_rdata, 64'h1);
        cycle(1'b1, 1'b1, C_BASE + 64'h10, 64'h2, 1'b0, "t4_clr");
        cycle(1'b1, 1'b0, C_BASE + 64'h18, 64'b0, 1'b0, "t4_rd_drop0");
        chk("t4_drop_cleared", perf_rdata, 64'h0);

        // 5: push into a full FIFO while popping
        cycle(1'b1, 1'b1, C_BASE, 64'hBEEF, 1'b1, "t5_push_pop");
        cycle(1'b1, 1'b0, C_BASE + 64'h08, 64'b0, 1'b0, "t5_rd_status");
        chk("t5_status_const", perf_rdata, 64'h0010_0002);
        cycle(1'b1, 1'b0, C_BASE + 64'h18, 64'b0, 1'b0, "t5_rd_drop");
        chk("t5_drop_const", perf_rdata, 64'h0);

        // 6: misses and disabled accesses, then flush
        cycle(1'b1, 1'b0, C_BASE + 64'h20, 64'b0, 1'b0, "t6_miss_rd");
        cycle(1'b0, 1'b1, C_BASE, 64'hDEAD, 1'b0, "t6_en0_wr");
        cycle(1'b1, 1'b1, C_BASE + 64'h08, 64'h55, 1'b0, "t6_ro_wr");
        cycle(1'b1, 1'b1, C_BASE + 64'h10, 64'h1, 1'b1, "t6_flush");
        cycle(1'b1, 1'b0, C_BASE + 64'h08, 64'b0, 1'b0, "t6_rd_status");
        chk("t6_status_const", perf_rdata, 64'h1);
        cycle(1'b1, 1'b0, C_BASE + 64'h00, 64'b0, 1'b0, "t6_rd_data");
        cycle(1'b1, 1'b0, C_BASE + 64'h10, 64'b0, 1'b0, "t6_rd_ctrl");

        // Randomized traffic with phases of varying drain pressure
        for (int i = 0; i < 800; i++) begin
            logic        en;
            logic        wr;
            logic [63:0] addr;
            logic [63:0] data;
            logic        rdy;
            int          sel;
            en   = ($urandom_range(0, 3) != 0);
            wr   = ($urandom_range(0, 1) != 0);
            sel  = $urandom_range(0, 15);
            addr = C_BASE + {59'b0, 5'($urandom_range(0, 31))};
            if (sel == 0) addr = C_BASE + 64'h20 + 64'($urandom_range(0, 31));
            if (sel == 1) addr = C_BASE ^ 64'h0000_0100_0000_0000;
            if (sel >= 8) addr[4:3] = 2'd0;
            data = {$urandom, $urandom};
            if (addr[4:3] == 2'd2) begin
                data[0] = ($urandom_range(0, 7) == 0);
                data[1] = ($urandom_range(0, 3) == 0);
            end
            case ((i / 100) % 4)
                0:       rdy = ($urandom_range(0, 7) == 0);
                1:       rdy = ($urandom_range(0, 1) == 0);
                2:       rdy = ($urandom_range(0, 7) != 0);
                default: rdy = ($urandom_range(0, 2) == 0);
            endcase
            cycle(en, wr, addr, data, rdy, "rand");
        end

        // Reset mid-operation with a read in the reset cycle
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, C_BASE, 64'h7700 + 64'(i), 1'b0, "pre_rst_push");
        do_reset(1'b1);
        idle(1'b0);
        cycle(1'b1, 1'b0, C_BASE + 64'h08, 64'b0, 1'b0, "post_rst_status");
        chk("post_rst_status_const", perf_rdata, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
